ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 2048, CLK cycles the host holds the PS/2 clock low before the start bit (at least 100 us).
REQ-002 Parameter TIMEOUT_CYCLES, default 262144, maximum CLK cycles allowed between consecutive device clock falling edges (and after release) before abort.
REQ-003 CLK  in  1  system clock; all logic is clocked on its rising edge.
REQ-004 RST  in  1  reset, synchronous, active-low.
REQ-005 WR_STB  in  1  one-cycle write strobe from the CPU decode logic.
REQ-006 WR_DATA  in  8  command byte sampled on WR_STB.
REQ-007 KB_CLK_IN  in  1  raw PS/2 clock line level; asynchronous.
REQ-008 KB_DATA_IN  in  1  raw PS/2 data line level; asynchronous.
REQ-009 KB_CLK_OE  out  1  1 = pull PS/2 clock low (open-drain); 0 = release.
REQ-010 KB_DATA_OE  out  1  1 = pull PS/2 data low (open-drain); 0 = release.
REQ-011 BUSY  out  1  high from the cycle after an accepted WR_STB until the return to IDLE.
REQ-012 DONE  out  1  one-cycle pulse when a frame ends, whether it succeeded or failed.
REQ-013 ACK_ERR  out  1  sticky flag: the device did not acknowledge the last frame.
REQ-014 TIMEOUT_ERR  out  1  sticky flag: the watchdog expired during the last frame.
REQ-015 RX_INHIBIT  out  1  equals BUSY; tells the keyboard receiver to ignore the line while it is high.

Function
REQ-016 Both KB inputs SHALL pass through 2-FF synchronizers; a falling edge (FE) is a synchronized 1-to-0 transition, detected 3 cycles after the pin changes.
REQ-017 States: IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE.
REQ-018 IDLE: WR_STB latches WR_DATA into the shift register, clears ACK_ERR and TIMEOUT_ERR, and moves to INHIBIT; while not IDLE, WR_STB SHALL be ignored with no side effects.
REQ-019 INHIBIT: KB_CLK_OE=1 for exactly INHIBIT_CYCLES cycles; KB_DATA_OE SHALL assert in the last inhibit cycle; then go to START.
REQ-020 START: KB_CLK_OE=0, KB_DATA_OE=1 (start bit 0); the bit counter resets to 0; the watchdog starts.
REQ-021 In START/SHIFT, each FE SHALL present the next bit: FE1-FE8 send data bits 0-7 LSB first, FE9 sends odd parity (1 when data has an even number of 1s), FE10 releases data (stop bit 1); KB_DATA_OE = inverse of the bit, updated the cycle after the FE.
REQ-022 After FE10 go to ACK; on FE11, sample synchronized data: 0 = acknowledged, 1 = set ACK_ERR; then go to WAIT_IDLE.
REQ-023 WAIT_IDLE: wait until synchronized clock and data are both 1, then pulse DONE and go to IDLE.
REQ-024 The watchdog SHALL reload on entering START and on every FE; at TIMEOUT_CYCLES with no FE it sets TIMEOUT_ERR, releases both lines, pulses DONE and returns to IDLE.
REQ-025 The bit counter is 4 bits; values above 11 SHALL never occur.
REQ-026 In IDLE and WAIT_IDLE both OE outputs SHALL be 0; KB_CLK_OE SHALL be 1 only in INHIBIT.
REQ-027 A glitch-free FE SHALL be required; a synchronized clock low with no preceding 1 SHALL NOT count.

Reset
REQ-028 RST low SHALL force, on the next CLK edge: state IDLE, KB_CLK_OE=0, KB_DATA_OE=0, BUSY=0, DONE=0, ACK_ERR=0, TIMEOUT_ERR=0, counters 0, shift register 0, synchronizers to 1.
REQ-029 Reset in the middle of a frame SHALL release both lines immediately, and SHALL NOT pulse DONE.

Structure
REQ-030 Shared package ps2_pkg holds: the state enum, the default INHIBIT/TIMEOUT constants, and the odd-parity function, shared with the keyboard receiver.
REQ-031 Sub-module ps2_sync_edge (2-FF synchronizer plus FE detector), instantiated once per line and reusable by the receiver.

Verification
REQ-032 WR_DATA=0xED, device model clocks at 12.5 kHz and ACKs -> bits 1,0,1,1,0,1,1,1, parity 1, stop 1; DONE=1, ACK_ERR=0.
REQ-033 WR_DATA=0x01 and 0xFF -> parity bits 0 and 1 respectively; KB_CLK_OE high for exactly 2048 cycles in each case.
REQ-034 Device leaves data high on FE11 -> ACK_ERR=1, DONE pulses once, BUSY falls.
REQ-035 Device never clocks after release -> TIMEOUT_ERR=1 after 262144 cycles, both OE outputs 0, DONE=1.
REQ-036 WR_STB=0x55 mid-frame of 0xF4 -> the frame carries 0xF4 unchanged; 0x55 is never sent.
REQ-037 RST low at FE5 -> next cycle both OE outputs 0, BUSY=0, no DONE; the next write completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmit FSM states, default timing constants,
// and the odd-parity helper also used by the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_state_e;

  localparam int PS2_INHIBIT_CYCLES = 2048;
  localparam int PS2_TIMEOUT_CYCLES = 262144;

  // PS/2 parity bit: 1 when the data byte holds an even number of ones.
  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge detector
// that needs a synchronized 1 followed by a synchronized 0.
module ps2_sync_edge (
  input  logic CLK,
  input  logic RST,
  input  logic i_pin,
  output logic o_sync,
  output logic o_fe
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_meta   <= i_pin;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fe   = r_sync_d & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start bit, 8 data bits,
// odd parity, stop, device acknowledge, with a watchdog on the device clock.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WR_STB,
  input  logic [7:0] WR_DATA,
  input  logic       KB_CLK_IN,
  input  logic       KB_DATA_IN,
  output logic       KB_CLK_OE,
  output logic       KB_DATA_OE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ACK_ERR,
  output logic       TIMEOUT_ERR,
  output logic       RX_INHIBIT,
  output ps2_state_e DBG_STATE
);

  localparam int IW = $clog2(INHIBIT_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  ps2_state_e  r_state;
  logic          r_clk_oe;
  logic          r_data_oe;
  logic          r_busy;
  logic          r_done;
  logic          r_ack_err;
  logic          r_tmo_err;
  logic [IW-1:0] r_inh_cnt;
  logic [TW-1:0] r_wdog;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;

  logic w_clk_sync;
  logic w_clk_fe;
  logic w_data_sync;
  logic w_data_fe;

  ps2_sync_edge u_clk_sync (
    .CLK    (CLK),
    .RST    (RST),
    .i_pin  (KB_CLK_IN),
    .o_sync (w_clk_sync),
    .o_fe   (w_clk_fe)
  );

  ps2_sync_edge u_data_sync (
    .CLK    (CLK),
    .RST    (RST),
    .i_pin  (KB_DATA_IN),
    .o_sync (w_data_sync),
    .o_fe   (w_data_fe)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_tmo_err <= 1'b0;
      r_inh_cnt <= '0;
      r_wdog    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          if (WR_STB) begin
            r_shift   <= WR_DATA;
            r_ack_err <= 1'b0;
            r_tmo_err <= 1'b0;
            r_busy    <= 1'b1;
            r_clk_oe  <= 1'b1;
            r_inh_cnt <= '0;
            r_state   <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          // Data is pulled low one cycle before clock release so the start bit is set up.
          if (r_inh_cnt == IW'(INHIBIT_CYCLES - 2)) r_data_oe <= 1'b1;
          if (r_inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
            r_clk_oe  <= 1'b0;
            r_inh_cnt <= '0;
            r_bit_cnt <= '0;
            r_wdog    <= '0;
            r_state   <= ST_START;
          end else begin
            r_inh_cnt <= r_inh_cnt + IW'(1);
          end
        end
        ST_START, ST_SHIFT, ST_ACK: begin
          if (w_clk_fe) begin
            r_wdog    <= '0;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_state == ST_ACK) begin
              r_ack_err <= w_data_sync;
              r_state   <= ST_WAIT_IDLE;
            end else if (r_bit_cnt < 4'd8) begin
              r_data_oe <= ~r_shift[r_bit_cnt[2:0]];
              r_state   <= ST_SHIFT;
            end else if (r_bit_cnt == 4'd8) begin
              r_data_oe <= ~ps2_odd_parity(r_shift);
            end else begin
              r_data_oe <= 1'b0;
              r_state   <= ST_ACK;
            end
          end else if (r_wdog == TW'(TIMEOUT_CYCLES - 1)) begin
            r_tmo_err <= 1'b1;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_bit_cnt <= '0;
            r_wdog    <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + TW'(1);
          end
        end
        ST_WAIT_IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          if (w_clk_sync && w_data_sync) begin
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_bit_cnt <= '0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign KB_CLK_OE   = r_clk_oe;
  assign KB_DATA_OE  = r_data_oe;
  assign BUSY        = r_busy;
  assign RX_INHIBIT  = r_busy;
  assign DONE        = r_done;
  assign ACK_ERR     = r_ack_err;
  assign TIMEOUT_ERR = r_tmo_err;
  assign DBG_STATE   = r_state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model, scripted PS/2 device, and a
// DONE-driven scoreboard fed by a frame-level reference model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 2048;
  localparam int TMO = 3000;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       WR_STB = 1'b0;
  logic [7:0] WR_DATA = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       KB_CLK_OE, KB_DATA_OE, BUSY, DONE, ACK_ERR, TIMEOUT_ERR, RX_INHIBIT;
  ps2_state_e dbg_state;
  logic       kb_clk_line, kb_data_line;

  assign kb_clk_line  = ~(KB_CLK_OE | dev_clk_low);
  assign kb_data_line = ~(KB_DATA_OE | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .WR_STB      (WR_STB),
    .WR_DATA     (WR_DATA),
    .KB_CLK_IN   (kb_clk_line),
    .KB_DATA_IN  (kb_data_line),
    .KB_CLK_OE   (KB_CLK_OE),
    .KB_DATA_OE  (KB_DATA_OE),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .ACK_ERR     (ACK_ERR),
    .TIMEOUT_ERR (TIMEOUT_ERR),
    .RX_INHIBIT  (RX_INHIBIT),
    .DBG_STATE   (dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int checks = 0;
  int fails  = 0;

  // scoreboard entry: {timeout_err, ack_err, check_frame, frame[10:0]}
  logic [13:0] exp_q[$];
  logic [10:0] cap_frame = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference frame on the wire: start 0, data LSB first, parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int ones = 0;
    logic par;
    for (int b = 0; b < 8; b++) ones += int'(d[b]);
    par = (ones % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  // monitor: every DONE pops one expected frame result
  always @(negedge CLK) begin
    logic [13:0] e;
    if (RST && DONE) begin
      check("done_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ack_err", 32'(ACK_ERR), 32'(e[12]));
        check("timeout_err", 32'(TIMEOUT_ERR), 32'(e[13]));
        check("busy_at_done", 32'({BUSY, RX_INHIBIT}), 0);
        check("oe_at_done", 32'({KB_CLK_OE, KB_DATA_OE}), 0);
        if (e[11]) check("frame_bits", 32'(cap_frame), 32'(e[10:0]));
      end
    end
  end

  // monitor: inhibit pulse length and data setup in its last cycle
  int   inh_cnt = 0;
  logic last_doe = 1'b0;
  always @(negedge CLK) begin
    if (!RST) inh_cnt = 0;
    else if (KB_CLK_OE) begin
      inh_cnt++;
      last_doe = KB_DATA_OE;
    end else if (inh_cnt > 0) begin
      check("inhibit_len", 32'(inh_cnt), INH);
      check("data_oe_last_inhibit", 32'(last_doe), 1);
      inh_cnt = 0;
    end
  end

  // driver tasks
  task automatic strobe_only(input logic [7:0] d);
    @(negedge CLK);
    WR_DATA = d;
    WR_STB  = 1'b1;
    @(negedge CLK);
    WR_STB  = 1'b0;
    WR_DATA = 8'h00;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic [2:0] flags);
    @(negedge CLK);
    WR_DATA = d;
    WR_STB  = 1'b1;
    exp_q.push_back({flags, model_frame(d)});
    @(negedge CLK);
    WR_STB  = 1'b0;
    check("busy_after_write", 32'({BUSY, RX_INHIBIT}), 3);
    check("flags_cleared", 32'({ACK_ERR, TIMEOUT_ERR}), 0);
  endtask

  // mode 0 = ACK, 1 = no ACK, 2 = silent device
  task automatic device_frame(input int mode, input int half, input int inject_at, input int reset_at);
    logic [10:0] cap;
    int n;
    cap = '0;
    n = 0;
    while (KB_CLK_OE && n < INH + 100) begin
      @(negedge CLK);
      n++;
    end
    check("inhibit_release", 32'(KB_CLK_OE), 0);
    if (mode == 2) return;
    repeat (20) @(negedge CLK);
    for (int i = 1; i <= 11; i++) begin
      cap[i-1] = kb_data_line;
      if (i == 11) cap_frame = cap;
      if (i == 11 && mode == 0) dev_data_low = 1'b1;
      repeat (5) @(negedge CLK);
      dev_clk_low = 1'b1;
      if (i == inject_at) strobe_only(8'h55);
      if (i == reset_at) begin
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("reset_mid_oe", 32'({KB_CLK_OE, KB_DATA_OE}), 0);
        check("reset_mid_busy_done", 32'({BUSY, DONE}), 0);
        RST = 1'b1;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        void'(exp_q.pop_back());
        return;
      end
      repeat (half) @(negedge CLK);
      dev_clk_low = 1'b0;
      repeat (half) @(negedge CLK);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] d, input int mode, input int half,
                           input int inject_at, input int reset_at);
    logic [2:0] flags;
    int n;
    case (mode)
      1:       flags = 3'b011;
      2:       flags = 3'b100;
      default: flags = 3'b001;
    endcase
    write_byte(d, flags);
    device_frame(mode, half, inject_at, reset_at);
    n = 0;
    while (exp_q.size() != 0 && n < TMO + 500) begin
      @(negedge CLK);
      n++;
    end
    check("done_within_bound", 32'(exp_q.size()), 0);
    exp_q.delete();
    repeat (10) @(negedge CLK);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge CLK);
    check("rst_oe", 32'({KB_CLK_OE, KB_DATA_OE}), 0);
    check("rst_busy_done", 32'({BUSY, DONE, RX_INHIBIT}), 0);
    check("rst_flags", 32'({ACK_ERR, TIMEOUT_ERR}), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    RST = 1'b1;
    repeat (5) @(negedge CLK);

    run_frame(8'hED, 0, 40, 0, 0);
    run_frame(8'h01, 0, 40, 0, 0);
    run_frame(8'hFF, 0, 40, 0, 0);
    run_frame(8'h3C, 1, 40, 0, 0);
    run_frame(8'hAA, 2, 40, 0, 0);
    run_frame(8'hF4, 0, 40, 4, 0);

    seen = 0;
    repeat (100) begin
      @(negedge CLK);
      if (KB_CLK_OE || BUSY) seen++;
    end
    check("no_extra_frame", 32'(seen), 0);

    run_frame(8'h5A, 0, 40, 0, 5);
    run_frame(8'h12, 0, 40, 0, 0);

    for (int k = 0; k < 6; k++) begin
      run_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0) ? 1 : 0,
                $urandom_range(30, 50), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
